video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Free-running raster timing generator: counts pixels and lines on the pixel clock enable and drives horizontal/vertical blanking and sync for the game core. It is the source end of the sync path that the resync stage consumes. Sync position is trimmable by signed 4-bit offsets. Offsets are latched once per frame, so changing them never tears a line or a frame.

## Interface
- CNTW, 10: counter width; all timing parameters are below 2^CNTW
- HTOTAL, 384: pixels per line
- HB_START, 256: first blanked pixel
- HB_END, 0: first active pixel; requires HB_END < HB_START
- HS_START, 288: nominal HS rising pixel
- HS_LEN, 32: HS width in pixels; range 1..HTOTAL-1
- VTOTAL, 262: lines per frame
- VB_START, 240: first blanked line
- VB_END, 0: first active line; requires VB_END < VB_START
- VS_START, 244: nominal VS rising line
- VS_LEN, 4: VS width in lines; range 1..VTOTAL-1
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pxl_cen  in  1  pixel clock enable; all state advances only when high
- hoffset  in  4  signed two's-complement horizontal sync trim (-8..+7 pixels)
- voffset  in  4  signed two's-complement vertical sync trim (-8..+7 lines)
- hcnt  out  CNTW  current pixel, 0..HTOTAL-1
- vcnt  out  CNTW  current line, 0..VTOTAL-1
- LHBL  out  1  high in the active horizontal region
- LVBL  out  1  high in the active vertical region
- hs  out  1  horizontal sync, active high
- vs  out  1  vertical sync, active high
- frame_start  out  1  one pxl_cen-cycle pulse at hcnt=0, vcnt=0

## Operation
- hcnt increments each pxl_cen and wraps HTOTAL-1 -> 0. vcnt increments on that wrap and wraps VTOTAL-1 -> 0.
- LHBL = (HB_END <= hcnt < HB_START). LVBL = (VB_END <= vcnt < VB_START).
- Effective sync start:
  - hs_pos = (HS_START + sext(hoffset)) mod HTOTAL
  - vs_pos = (VS_START + sext(voffset)) mod VTOTAL
  - Sign-extend to CNTW+1 bits, then wrap by a single add or subtract of the total.
- hs_pos and vs_pos are recomputed from the offset inputs only at the frame wrap (hcnt=HTOTAL-1, vcnt=VTOTAL-1, pxl_cen). Offset changes therefore take effect from the next frame.
- HS:
  - Rises at hcnt==hs_pos.
  - A hold counter loaded with HS_LEN-1 keeps it high for exactly HS_LEN pixels.
  - The pulse may span the line wrap.
- VS:
  - Evaluated only when hcnt==hs_pos, so the VS edge is aligned with the HS rising edge.
  - Rises when vcnt==vs_pos, then holds for VS_LEN lines, counting one per hs_pos match.
  - May span the frame wrap.
- A pulse already in progress finishes with its original length, even when hs_pos or vs_pos is re-latched during it.
- Parameter legality (HB_END < HB_START, VB_END < VB_START, HS_LEN and VS_LEN ranges) is checked only by simulation assertions.

## Timing
- All outputs are registered. hcnt, vcnt, LHBL, LVBL, hs, vs and frame_start are mutually aligned: each flop reflects the same counter value in the same cycle. Blanking and sync are computed from the next counter value.
- Reset values:
  - hcnt = 0, vcnt = 0
  - LHBL = 0, LVBL = 0, hs = 0, vs = 0, frame_start = 0
  - Hold counters = 0
  - hs_pos = HS_START, vs_pos = VS_START
- After reset release, the first pxl_cen moves to hcnt = 1. Outputs then follow the decode rules above; no resync delay.
- Reset asserted mid-frame clears everything asynchronously, including a sync pulse in progress.
- While pxl_cen is low, every register holds.
- frame_start is high for exactly one pxl_cen period per frame. It is cleared on the next pxl_cen.

## Structure
- Shared package holds:
  - CNTW
  - Default timing constants (HTOTAL…VS_LEN)
  - A function that computes the wrapped signed offset sum
- One sub-module, sync_pulse, instantiated twice (HS and VS):
  - Inputs: pxl_cen-qualified step strobe, start match, length
  - Output: registered pulse
  - Contains the hold counter

## Test plan
- Default free-run:
  - LHBL falls at hcnt 256 and rises at 0.
  - hs is high for hcnt 288..319.
  - LVBL falls at vcnt 240.
  - vs rises at vcnt 244 with hcnt 288 and lasts 4 lines.
  - frame_start period is 100608 pxl_cen.
- hoffset=4'b1000 (-8) written at vcnt 100 -> the current frame keeps hs at 288; from the next frame hs rises at 280.
- HS_START=380, hoffset=+7 -> hs rises at hcnt 3 and spans 32 pixels; no pulse appears at 380..383.
- voffset=+3 and hoffset=-8 -> vs rises at vcnt 247, hcnt 280, and falls at vcnt 251, hcnt 280.
- pxl_cen low for 5 clocks at hcnt 290 -> hcnt, hs and the hold count are frozen; the pulse still totals 32 pxl_cen.
- rst pulsed at hcnt 300, vcnt 245 (hs and vs high) -> all outputs 0 immediately. After release, counting starts from 0 and the next vs appears at vcnt 244.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// Shared width, default raster timing and the wrapped sync-position helper
// for the video timing generator.
package video_timing_gen_pkg;

  localparam int CNTW     = 10;
  localparam int HTOTAL   = 384;
  localparam int HB_START = 256;
  localparam int HB_END   = 0;
  localparam int HS_START = 288;
  localparam int HS_LEN   = 32;
  localparam int VTOTAL   = 262;
  localparam int VB_START = 240;
  localparam int VB_END   = 0;
  localparam int VS_START = 244;
  localparam int VS_LEN   = 4;

  // base + sext(off), folded back into 0..total-1 with one add or subtract.
  function automatic logic [CNTW-1:0] wrap_pos(
    input logic [CNTW-1:0] base,
    input logic [3:0]      off,
    input logic [CNTW-1:0] total
  );
    logic signed [CNTW:0] sum;
    logic signed [CNTW:0] tot;
    tot = $signed({1'b0, total});
    sum = $signed({1'b0, base}) + $signed({{(CNTW-3){off[3]}}, off});
    if (sum < 0)
      sum = sum + tot;
    else if (sum >= tot)
      sum = sum - tot;
    return sum[CNTW-1:0];
  endfunction

endpackage

// File: rtl/video_timing_gen_sync_pulse.sv
// Registered sync pulse: starts on a match and stays high for len steps,
// ignoring further matches until the current pulse has finished.
module sync_pulse
  import video_timing_gen_pkg::*;
#(
  parameter int CNTW_P = video_timing_gen_pkg::CNTW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              start,
  input  logic [CNTW_P-1:0] len,
  output logic              pulse
);

  logic              pulse_reg;
  logic [CNTW_P-1:0] hold_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_reg <= 1'b0;
      hold_reg  <= '0;
    end else if (step) begin
      if (pulse_reg && hold_reg != '0) begin
        hold_reg <= hold_reg - CNTW_P'(1);
      end else if (start) begin
        pulse_reg <= 1'b1;
        hold_reg  <= len - CNTW_P'(1);
      end else begin
        pulse_reg <= 1'b0;
      end
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster counter with blanking, trimmable sync and a frame
// marker; every output is registered from the next counter value.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int CNTW     = video_timing_gen_pkg::CNTW,
  parameter int HTOTAL   = video_timing_gen_pkg::HTOTAL,
  parameter int HB_START = video_timing_gen_pkg::HB_START,
  parameter int HB_END   = video_timing_gen_pkg::HB_END,
  parameter int HS_START = video_timing_gen_pkg::HS_START,
  parameter int HS_LEN   = video_timing_gen_pkg::HS_LEN,
  parameter int VTOTAL   = video_timing_gen_pkg::VTOTAL,
  parameter int VB_START = video_timing_gen_pkg::VB_START,
  parameter int VB_END   = video_timing_gen_pkg::VB_END,
  parameter int VS_START = video_timing_gen_pkg::VS_START,
  parameter int VS_LEN   = video_timing_gen_pkg::VS_LEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pxl_cen,
  input  logic [3:0]      hoffset,
  input  logic [3:0]      voffset,
  output logic [CNTW-1:0] hcnt,
  output logic [CNTW-1:0] vcnt,
  output logic            LHBL,
  output logic            LVBL,
  output logic            hs,
  output logic            vs,
  output logic            frame_start
);

  localparam logic [CNTW-1:0] HT_C   = CNTW'(HTOTAL);
  localparam logic [CNTW-1:0] VT_C   = CNTW'(VTOTAL);
  localparam logic [CNTW-1:0] HT_M1  = CNTW'(HTOTAL - 1);
  localparam logic [CNTW-1:0] VT_M1  = CNTW'(VTOTAL - 1);
  localparam logic [CNTW-1:0] HBS_C  = CNTW'(HB_START);
  localparam logic [CNTW-1:0] HBE_C  = CNTW'(HB_END);
  localparam logic [CNTW-1:0] VBS_C  = CNTW'(VB_START);
  localparam logic [CNTW-1:0] VBE_C  = CNTW'(VB_END);
  localparam logic [CNTW-1:0] HSS_C  = CNTW'(HS_START);
  localparam logic [CNTW-1:0] VSS_C  = CNTW'(VS_START);
  localparam logic [CNTW-1:0] HSL_C  = CNTW'(HS_LEN);
  localparam logic [CNTW-1:0] VSL_C  = CNTW'(VS_LEN);

  logic [CNTW-1:0] hcnt_reg, hcnt_next;
  logic [CNTW-1:0] vcnt_reg, vcnt_next;
  logic [CNTW-1:0] hs_pos_reg, hs_pos_next;
  logic [CNTW-1:0] vs_pos_reg, vs_pos_next;
  logic            lhbl_reg, lvbl_reg, frame_start_reg;
  logic            line_wrap, frame_wrap, hs_match;

  always_comb begin
    line_wrap   = (hcnt_reg == HT_M1);
    frame_wrap  = line_wrap && (vcnt_reg == VT_M1);
    hcnt_next   = line_wrap ? '0 : hcnt_reg + CNTW'(1);
    vcnt_next   = vcnt_reg;
    if (line_wrap)
      vcnt_next = (vcnt_reg == VT_M1) ? '0 : vcnt_reg + CNTW'(1);
    hs_pos_next = wrap_pos(HSS_C, hoffset, HT_C);
    vs_pos_next = wrap_pos(VSS_C, voffset, VT_C);
    hs_match    = (hcnt_next == hs_pos_reg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_reg        <= '0;
      vcnt_reg        <= '0;
      lhbl_reg        <= 1'b0;
      lvbl_reg        <= 1'b0;
      frame_start_reg <= 1'b0;
      hs_pos_reg      <= HSS_C;
      vs_pos_reg      <= VSS_C;
    end else if (pxl_cen) begin
      hcnt_reg        <= hcnt_next;
      vcnt_reg        <= vcnt_next;
      lhbl_reg        <= (hcnt_next >= HBE_C) && (hcnt_next < HBS_C);
      lvbl_reg        <= (vcnt_next >= VBE_C) && (vcnt_next < VBS_C);
      frame_start_reg <= (hcnt_next == '0) && (vcnt_next == '0);
      // Offsets only move sync at the frame boundary so no line or frame tears.
      if (frame_wrap) begin
        hs_pos_reg <= hs_pos_next;
        vs_pos_reg <= vs_pos_next;
      end
    end
  end

  // Index 0 is HS (steps every pixel), index 1 is VS (steps on each HS start).
  logic            sp_step  [2];
  logic            sp_start [2];
  logic [CNTW-1:0] sp_len   [2];
  logic            sp_pulse [2];

  assign sp_step[0]  = pxl_cen;
  assign sp_start[0] = hs_match;
  assign sp_len[0]   = HSL_C;
  assign sp_step[1]  = pxl_cen && hs_match;
  assign sp_start[1] = (vcnt_next == vs_pos_reg);
  assign sp_len[1]   = VSL_C;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      sync_pulse #(.CNTW_P(CNTW)) u_sync_pulse (
        .clk   (clk),
        .rst   (rst),
        .step  (sp_step[gi]),
        .start (sp_start[gi]),
        .len   (sp_len[gi]),
        .pulse (sp_pulse[gi])
      );
    end
  endgenerate

  assign hcnt        = hcnt_reg;
  assign vcnt        = vcnt_reg;
  assign LHBL        = lhbl_reg;
  assign LVBL        = lvbl_reg;
  assign hs          = sp_pulse[0];
  assign vs          = sp_pulse[1];
  assign frame_start = frame_start_reg;

  // Elaboration-constant legality checks, evaluated in simulation only.
  always_ff @(posedge clk) begin
    assert (HB_END < HB_START) else $error("video_timing_gen: HB_END must be below HB_START");
    assert (VB_END < VB_START) else $error("video_timing_gen: VB_END must be below VB_START");
    assert (HS_LEN >= 1 && HS_LEN <= HTOTAL - 1) else $error("video_timing_gen: HS_LEN out of range");
    assert (VS_LEN >= 1 && VS_LEN <= VTOTAL - 1) else $error("video_timing_gen: VS_LEN out of range");
    assert (HTOTAL < (1 << CNTW) && VTOTAL < (1 << CNTW)) else $error("video_timing_gen: totals exceed CNTW");
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench on a reduced raster (40 x 20) so full frames stay short;
// expected positions are worked out by hand from the reduced parameters.
module tb_video_timing_gen;

  localparam int CNTW = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pxl_cen = 1'b0;
  logic [3:0]      hoffset = 4'd0;
  logic [3:0]      voffset = 4'd0;
  logic [CNTW-1:0] hcnt, vcnt;
  logic            LHBL, LVBL, hs, vs, frame_start;

  int total = 0;
  int bad   = 0;

  video_timing_gen #(
    .CNTW(CNTW), .HTOTAL(40), .HB_START(32), .HB_END(2), .HS_START(36), .HS_LEN(4),
    .VTOTAL(20), .VB_START(15), .VB_END(1), .VS_START(16), .VS_LEN(2)
  ) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .hoffset(hoffset), .voffset(voffset),
    .hcnt(hcnt), .vcnt(vcnt), .LHBL(LHBL), .LVBL(LVBL), .hs(hs), .vs(vs),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (h=%0d v=%0d)", tag, obs, exp, hcnt, vcnt);
    end
    $display("check %-14s h=%0d v=%0d observed=%0d expected=%0d", tag, hcnt, vcnt, obs, exp);
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic seek(input int h, input int v);
    int n;
    n = 0;
    while (!(hcnt == h && vcnt == v) && n < 1000) begin
      adv(1);
      n++;
    end
    chk("seek_reached", (hcnt == h && vcnt == v), 1);
  endtask

  initial begin
    int n;
    // Reset state
    adv(3);
    chk("rst_hcnt", hcnt, 0);
    chk("rst_vcnt", vcnt, 0);
    chk("rst_lhbl", LHBL, 0);
    chk("rst_lvbl", LVBL, 0);
    chk("rst_hs", hs, 0);
    chk("rst_vs", vs, 0);
    chk("rst_fs", frame_start, 0);
    rst = 1'b0;
    pxl_cen = 1'b1;
    adv(1);
    chk("first_hcnt", hcnt, 1);
    chk("lhbl_h1", LHBL, 0);
    adv(1);
    chk("lhbl_h2", LHBL, 1);

    // Horizontal blanking and HS on default offsets
    seek(31, 1);
    chk("lhbl_h31", LHBL, 1);
    chk("lvbl_v1", LVBL, 1);
    adv(1);
    chk("lhbl_h32", LHBL, 0);
    seek(35, 1);
    chk("hs_h35", hs, 0);
    adv(1);
    chk("hs_h36", hs, 1);
    adv(3);
    chk("hs_h39", hs, 1);
    adv(1);
    chk("hs_h0", hs, 0);
    chk("vcnt_wrap", vcnt, 2);

    // Vertical blanking and VS
    seek(39, 14);
    chk("lvbl_v14", LVBL, 1);
    adv(1);
    chk("lvbl_v15", LVBL, 0);
    seek(35, 16);
    chk("vs_pre", vs, 0);
    adv(1);
    chk("vs_rise", vs, 1);
    seek(35, 18);
    chk("vs_hold", vs, 1);
    adv(1);
    chk("vs_fall", vs, 0);

    // Frame start pulse and period
    seek(39, 19);
    chk("fs_pre", frame_start, 0);
    adv(1);
    chk("fs_on", frame_start, 1);
    chk("lvbl_v0", LVBL, 0);
    n = 0;
    do begin
      adv(1);
      n++;
      if (n == 1) chk("fs_off", frame_start, 0);
    end while (frame_start == 1'b0 && n < 1000);
    chk("fs_period", n, 800);

    // hoffset -8 mid-frame: current frame keeps 36, next frame uses 28
    seek(0, 5);
    hoffset = 4'b1000;
    seek(35, 5);
    adv(1);
    chk("hs_old_pos", hs, 1);
    seek(27, 0);
    chk("hs_new_pre", hs, 0);
    adv(1);
    chk("hs_new_rise", hs, 1);
    adv(4);
    chk("hs_new_fall", hs, 0);

    // voffset +3: this frame VS still at line 16, next frame at 19 across wrap
    voffset = 4'd3;
    seek(27, 16);
    chk("vs_old_pre", vs, 0);
    adv(1);
    chk("vs_old_rise", vs, 1);
    seek(28, 19);
    chk("vs_no_early", vs, 0);
    seek(27, 19);
    chk("vs_new_pre", vs, 0);
    adv(1);
    chk("vs_new_rise", vs, 1);
    seek(27, 1);
    chk("vs_span_wrap", vs, 1);
    adv(1);
    chk("vs_new_fall", vs, 0);

    // hoffset +7: 36+7 wraps to pixel 3
    hoffset = 4'd7;
    voffset = 4'd0;
    seek(0, 0);
    seek(2, 0);
    chk("hs_wrap_pre", hs, 0);
    adv(1);
    chk("hs_wrap_rise", hs, 1);
    adv(3);
    chk("hs_wrap_h6", hs, 1);
    adv(1);
    chk("hs_wrap_fall", hs, 0);
    seek(37, 0);
    chk("hs_none_37", hs, 0);
    seek(39, 0);
    chk("hs_none_39", hs, 0);

    // hoffset +3: pulse at 39 spans the line wrap
    hoffset = 4'd3;
    seek(0, 0);
    seek(38, 0);
    chk("hs_ln_pre", hs, 0);
    adv(1);
    chk("hs_ln_rise", hs, 1);
    adv(1);
    chk("hs_ln_span", hs, 1);
    chk("hs_ln_vcnt", vcnt, 1);
    adv(2);
    chk("hs_ln_h2", hs, 1);
    adv(1);
    chk("hs_ln_fall", hs, 0);

    // pxl_cen held low mid-pulse freezes everything
    seek(0, 2);
    chk("frz_hs_in", hs, 1);
    pxl_cen = 1'b0;
    adv(5);
    chk("frz_hcnt", hcnt, 0);
    chk("frz_vcnt", vcnt, 2);
    chk("frz_hs", hs, 1);
    pxl_cen = 1'b1;
    adv(2);
    chk("frz_hs_h2", hs, 1);
    adv(1);
    chk("frz_hs_end", hs, 0);

    // Asynchronous reset during HS and VS
    hoffset = 4'd0;
    seek(1, 17);
    chk("prerst_hs", hs, 1);
    chk("prerst_vs", vs, 1);
    rst = 1'b1;
    #1;
    chk("arst_hcnt", hcnt, 0);
    chk("arst_vcnt", vcnt, 0);
    chk("arst_hs", hs, 0);
    chk("arst_vs", vs, 0);
    chk("arst_lhbl", LHBL, 0);
    chk("arst_lvbl", LVBL, 0);
    adv(2);
    rst = 1'b0;
    adv(1);
    chk("post_hcnt", hcnt, 1);
    chk("post_vcnt", vcnt, 0);
    seek(35, 0);
    adv(1);
    chk("post_hs_rise", hs, 1);
    seek(35, 16);
    chk("post_vs_pre", vs, 0);
    adv(1);
    chk("post_vs_rise", vs, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
